upc_tag_tx: RTL and testbench
=============================

Name: upc_tag_tx

Overview:
- Serial transmitter for item tags: frames a 3-bit UPC plus the paid/mark bit onto a single wire toward the exit-door stolen/discount detector.
- Sits at the checkout station. Software or the register map loads the tag; this block shifts it out.
- The door side deserialises the frame and feeds its combinational UPC classifiers.

Parameters:
- BIT_TICKS, 4, clock cycles per serial bit. Legal values are 2..255.
- UPC_W, 3, UPC field width. It is fixed at 3 and is exposed only for the package constants.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- upc_in  in  3  UPC code to send; sampled on the accept edge
- mark_in  in  1  paid/mark bit to send; sampled on the accept edge
- send  in  1  request to transmit
- ready  out  1  high in IDLE; a transfer occurs on any edge where send & ready
- tx_out  out  1  serial line, registered; idle level is 1
- done  out  1  one-cycle pulse during the final clock of the stop bit

Behaviour:
- Reset values:
  - tx_out=1, ready=1, done=0
  - state=IDLE; tick and bit counters = 0
- Frame order, with parity enabled (7 bits):
  - START (0)
  - upc[2], upc[1], upc[0]
  - mark
  - PARITY
  - STOP (1)
- Parity is even: the parity bit equals XOR of the 4 data bits, so the 5 bits together contain an even number of ones.
- Each bit lasts exactly BIT_TICKS cycles. tx_out is registered; no glitches at bit boundaries.
- FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - DATA uses a 2-bit index, 0..3.
  - The tick counter runs 0..BIT_TICKS-1. The state or bit index advances on the edge where tick==BIT_TICKS-1.
- Accept edge (send & ready):
  - upc_in and mark_in are latched into a shift register.
  - From the next cycle: ready=0 and tx_out=0 (start bit).
- Transfer length: ready stays low for exactly 7*BIT_TICKS cycles.
- done=1 on the last of those cycles only. The following cycle is IDLE with ready=1 and tx_out=1.
- send while busy is ignored; it is not queued.
- Input changes after the accept edge do not affect the frame in flight.
- Back-to-back: with send held high, there is exactly one idle-high cycle between a STOP bit and the next START bit.
- Reset mid-frame: on the reset edge the frame aborts. Next cycle tx_out=1, ready=1, done=0. No partial stop bit or done pulse is produced.
- Simultaneous reset and send: reset wins; nothing is accepted.

Optional Feature:
- Macro: UPC_TX_PARITY_EN
- Defined:
  - The PARITY state exists and the frame is 7 bits.
  - ready stays low for 7*BIT_TICKS cycles.
- Undefined:
  - The PARITY state is removed; DATA goes directly to STOP.
  - The frame is 6 bits and ready stays low for 6*BIT_TICKS cycles.
  - done and timing rules are otherwise identical.
- The receiver at the door must be built with the same setting.

Decomposition:
- Package upc_pkg holds:
  - UPC_W
  - the state enum typedef (IDLE, START, DATA, PARITY, STOP)
  - the frame length constant, 7 or 6 under the same macro
  - the data-bit count (4)
  - the line idle, start and stop level constants
- One sub-module, upc_bit_timer: BIT_TICKS down-counter.
  - Inputs: clear and enable.
  - Output: a one-cycle last_tick strobe.
  - The FSM uses it for all bit timing.

Test Plan (BIT_TICKS=4, parity enabled unless stated):
- Reset, then 10 idle cycles -> tx_out=1, ready=1, done=0 throughout.
- send=1 for one cycle with upc_in=3'b101, mark_in=0:
  - tx_out per 4-cycle bit = 0,1,0,1,0,0,1
  - ready low for 28 cycles
  - done high on cycle 28 only
- upc_in=3'b110, mark_in=1, and inputs changed to 3'b000 one cycle after the accept edge:
  - bits = 0,1,1,0,1,1,1 (parity=1)
  - the later change has no effect
- send held high across 2 frames (3'b000/0, then 3'b111/1):
  - the second start bit begins exactly 1 cycle after the first stop bit ends
  - second frame bits = 0,1,1,1,1,0,1
- Reset asserted in the middle of the DATA state:
  - next cycle tx_out=1, ready=1
  - no done pulse
  - a new send after that frames correctly
- UPC_TX_PARITY_EN undefined, upc_in=3'b011, mark_in=1:
  - bits = 0,0,1,1,1,1
  - ready low for 24 cycles
  - done on cycle 24

Source files
------------

// File: rtl/upc_tag_tx_pkg.sv
// Shared constants and state type for the UPC tag serial transmitter.
// UPC_TX_PARITY_EN selects the 7-bit (with even parity) or 6-bit frame.
package upc_pkg;

  localparam int UPC_W     = 3;
  localparam int DATA_BITS = 4;

`ifdef UPC_TX_PARITY_EN
  localparam int FRAME_BITS = 7;
`else
  localparam int FRAME_BITS = 6;
`endif

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

endpackage

// File: rtl/upc_tag_tx_if.sv
// Tag load handshake and serial line of the UPC tag transmitter.
// A tag is transferred on every rising edge where send & ready; send is not queued.
interface upc_tag_tx_if;
  import upc_pkg::*;

  logic [UPC_W-1:0] upc_in;
  logic             mark_in;
  logic             send;
  logic             ready;
  logic             tx_out;
  logic             done;
  state_e           dbg_state;

  modport master (
    output upc_in, mark_in, send,
    input  ready, tx_out, done, dbg_state
  );

  modport slave (
    input  upc_in, mark_in, send,
    output ready, tx_out, done, dbg_state
  );

endinterface

// File: rtl/upc_tag_tx_bit_timer.sv
// Bit-period down-counter: last_tick strobes on the final cycle of each bit.
module upc_bit_timer #(
  parameter int BIT_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_last_tick
);

  localparam logic [7:0] LOAD = 8'(BIT_TICKS - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if (i_clear) begin
      r_cnt <= LOAD;
    end else if (i_enable) begin
      r_cnt <= (r_cnt == 8'd0) ? LOAD : r_cnt - 8'd1;
    end
  end

  assign o_last_tick = i_enable && (r_cnt == 8'd0);

endmodule

// File: rtl/upc_tag_tx.sv
// Frames {start, upc[2:0], mark, [even parity], stop} onto a registered serial line.
// Build option: UPC_TX_PARITY_EN inserts the parity bit after the mark bit.
module upc_tag_tx
  import upc_pkg::*;
#(
  parameter int BIT_TICKS = 4
) (
  input  logic         clk,
  input  logic         reset,
  upc_tag_tx_if.slave  bus
);

  if (BIT_TICKS < 2 || BIT_TICKS > 255) begin : g_bad_ticks
    $error("BIT_TICKS must be in 2..255");
  end

  state_e      r_state, w_next_state;
  logic [3:0]  r_shift, w_next_shift;
  logic [1:0]  r_idx,   w_next_idx;
  logic        r_tx,    w_next_tx;
  logic        w_timer_clr;
  logic        w_timer_en;
  logic        w_last_tick;
`ifdef UPC_TX_PARITY_EN
  logic        r_parity;
`endif

  upc_bit_timer #(.BIT_TICKS(BIT_TICKS)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_timer_clr),
    .i_enable    (w_timer_en),
    .o_last_tick (w_last_tick)
  );

  assign w_timer_en = (r_state != IDLE);

  always_comb begin
    w_next_state = r_state;
    w_next_shift = r_shift;
    w_next_idx   = r_idx;
    w_timer_clr  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.send) begin
          w_next_state = START;
          w_next_shift = {bus.upc_in, bus.mark_in};
          w_next_idx   = 2'd0;
          w_timer_clr  = 1'b1;
        end
      end
      START: begin
        if (w_last_tick) begin
          w_next_state = DATA;
          w_next_idx   = 2'd0;
        end
      end
      DATA: begin
        if (w_last_tick) begin
          w_next_shift = {r_shift[2:0], 1'b0};
          if (r_idx == 2'(DATA_BITS - 1)) begin
`ifdef UPC_TX_PARITY_EN
            w_next_state = PARITY;
`else
            w_next_state = STOP;
`endif
          end else begin
            w_next_idx = r_idx + 2'd1;
          end
        end
      end
`ifdef UPC_TX_PARITY_EN
      PARITY: begin
        if (w_last_tick) w_next_state = STOP;
      end
`endif
      STOP: begin
        if (w_last_tick) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase

    // Line level is chosen from the state being entered so tx_out changes on the bit edge itself.
    w_next_tx = LINE_IDLE;
    unique case (w_next_state)
      IDLE:    w_next_tx = LINE_IDLE;
      START:   w_next_tx = LINE_START;
      DATA:    w_next_tx = w_next_shift[3];
`ifdef UPC_TX_PARITY_EN
      PARITY:  w_next_tx = r_parity;
`endif
      STOP:    w_next_tx = LINE_STOP;
      default: w_next_tx = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= 4'd0;
      r_idx   <= 2'd0;
      r_tx    <= LINE_IDLE;
    end else begin
      r_state <= w_next_state;
      r_shift <= w_next_shift;
      r_idx   <= w_next_idx;
      r_tx    <= w_next_tx;
    end
  end

`ifdef UPC_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (r_state == IDLE && bus.send) begin
      r_parity <= ^{bus.upc_in, bus.mark_in};
    end
  end
`endif

  assign bus.ready     = (r_state == IDLE);
  assign bus.tx_out    = r_tx;
  assign bus.done      = (r_state == STOP) && w_last_tick;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_upc_tag_tx.sv
// Bench for upc_tag_tx: accepted tags are predicted as whole frames, and a line
// monitor reassembles each frame from tx_out and compares it against the queue.
module tb_upc_tag_tx;

  localparam int BT = 4;
`ifdef UPC_TX_PARITY_EN
  localparam int LEN = 7;
`else
  localparam int LEN = 6;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  upc_tag_tx_if bus();

  upc_tag_tx #(.BIT_TICKS(BT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [LEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting, expected completion at %0t", name, $time);
  endtask

  // Reference frame: list the line levels in transmit order, then pack MSB-first.
  function automatic logic [LEN-1:0] model_frame(input logic [2:0] upc, input logic m);
    bit             bits[$];
    logic [LEN-1:0] f;
    bits.push_back(1'b0);
    for (int i = 2; i >= 0; i--) bits.push_back(upc[i]);
    bits.push_back(m);
`ifdef UPC_TX_PARITY_EN
    bits.push_back(($countones({upc, m}) % 2) == 1);
`endif
    bits.push_back(1'b1);
    f = '0;
    for (int i = 0; i < LEN; i++) f[LEN-1-i] = bits[i];
    return f;
  endfunction

  // Line monitor
  logic           mon_en  = 1'b0;
  logic           mon_pnd = 1'b0;
  logic           mon_act = 1'b0;
  int             mon_cyc = 0;
  logic [LEN-1:0] mon_got = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (mon_pnd) begin
        mon_act = 1'b1;
        mon_cyc = 0;
        mon_pnd = 1'b0;
      end
      if (mon_act) begin
        check("frame_ready_low", bus.ready, 0);
        check("frame_done", bus.done, (mon_cyc == LEN*BT-1) ? 1 : 0);
        if (mon_cyc % BT == 0) mon_got[LEN-1-mon_cyc/BT] = bus.tx_out;
        else check("bit_stable", bus.tx_out, mon_got[LEN-1-mon_cyc/BT]);
        mon_cyc++;
        if (mon_cyc == LEN*BT) begin
          mon_act = 1'b0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_unexpected: got %0h expected no frame", mon_got);
          end else begin
            check("frame_bits", mon_got, exp_q.pop_front());
          end
        end
      end else begin
        check("idle_line", {bus.ready, bus.tx_out, bus.done}, 3'b110);
      end
      if (rst) begin
        if (mon_act && exp_q.size() != 0) void'(exp_q.pop_front());
        mon_act = 1'b0;
      end else if (bus.send && bus.ready) begin
        mon_pnd = 1'b1;
        exp_q.push_back(model_frame(bus.upc_in, bus.mark_in));
      end
    end
  end

  // Driver tasks
  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ready && !rst) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    if (!ok) fail_timeout("accept");
  endtask

  task automatic send_frame(input logic [2:0] u, input logic m);
    bus.upc_in  = u;
    bus.mark_in = m;
    bus.send    = 1'b1;
    wait_accept();
    bus.send = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!mon_act && !mon_pnd && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) fail_timeout("idle");
  endtask

  initial begin
    bus.upc_in  = 3'd0;
    bus.mark_in = 1'b0;
    bus.send    = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cyc_wait(2);
    rst = 1'b0;
    cyc_wait(10);

    send_frame(3'b101, 1'b0);
    wait_idle();

    // Inputs change right after the accept edge; the frame must not notice.
    send_frame(3'b110, 1'b1);
    bus.upc_in  = 3'b000;
    bus.mark_in = 1'b0;
    wait_idle();

    // send held high across two frames.
    bus.upc_in  = 3'b000;
    bus.mark_in = 1'b0;
    bus.send    = 1'b1;
    wait_accept();
    bus.upc_in  = 3'b111;
    bus.mark_in = 1'b1;
    wait_accept();
    bus.send = 1'b0;
    wait_idle();

    // Reset in the middle of the data bits, then a clean frame.
    send_frame(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    cyc_wait(8);
    rst = 1'b1;
    cyc_wait(1);
    rst = 1'b0;
    cyc_wait(3);
    send_frame(3'b011, 1'b1);
    wait_idle();

    // Reset and send together: nothing may start.
    rst         = 1'b1;
    bus.send    = 1'b1;
    bus.upc_in  = 3'b100;
    cyc_wait(1);
    rst         = 1'b0;
    bus.send    = 1'b0;
    cyc_wait(4);

    for (int n = 0; n < 20; n++) begin
      send_frame(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        cyc_wait($urandom_range(1, 20));
        bus.upc_in  = 3'($urandom_range(0, 7));
        bus.mark_in = 1'($urandom_range(0, 1));
        bus.send    = 1'b1;
        cyc_wait(1);
        bus.send    = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) wait_idle();
      else cyc_wait($urandom_range(0, 2));
    end

    wait_idle();
    cyc_wait(2);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
